// File: rtl/param_pattern_history_table_pkg.sv
// Shared types and helpers for the pattern history table.
//   pht_fsm_e    : table state (initialising / ready)
//   pht_idx_w    : index width for a given PC/history width and hash mode
//   pht_depth    : number of table entries (2^index width)
//   pht_sat_next : saturating counter step for an arbitrary counter width
//   pht_index    : PC-bits/history combination (concatenate or XOR)
// Helpers work on 32-bit values so any instance width can share them; callers
// narrow the result with a size cast.
package param_pattern_history_table_pkg;

  typedef enum logic [0:0] {
    PHT_INIT  = 1'b0,
    PHT_READY = 1'b1
  } pht_fsm_e;

  function automatic int pht_idx_w(input int pc_idx_bits, input int hist_bits,
                                   input int hash_mode);
    return (hash_mode != 0) ? pc_idx_bits : pc_idx_bits + hist_bits;
  endfunction

  function automatic int pht_depth(input int pc_idx_bits, input int hist_bits,
                                   input int hash_mode);
    return 1 << pht_idx_w(pc_idx_bits, hist_bits, hash_mode);
  endfunction

  // One step of a ctr_w-bit saturating counter; never skips a state.
  function automatic logic [31:0] pht_sat_next(input logic [31:0] ctr, input logic taken,
                                               input int ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (taken) return (ctr >= max_v) ? max_v : ctr + 32'd1;
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

  // hash_mode 0: {pc_bits, hist}; hash_mode 1: pc_bits ^ zero-extended hist.
  function automatic logic [31:0] pht_index(input logic [31:0] pc_bits, input logic [31:0] hist,
                                            input int hist_bits, input int hash_mode);
    if (hash_mode != 0) return pc_bits ^ hist;
    return (pc_bits << hist_bits) | hist;
  endfunction

endpackage

// File: rtl/param_pattern_history_table_if.sv
// Bundle between fetch/execute logic (master) and the pattern history table (slave).
//   clear                       : master -> table, request full re-initialisation
//   ready                       : table -> master, table initialised, updates accepted
//   rd_valid/rd_pc/rd_hist      : lookup request, answered one cycle later
//   pred_valid/pred_taken/pred_ctr : registered lookup result
//   upd_valid/upd_pc/upd_hist/upd_taken : per-port resolved-branch updates
// Handshake: there is no back-pressure. rd_valid and upd_valid are single-cycle
// strobes that are sampled on every rising clock edge; pred_valid is rd_valid
// delayed by one cycle. Updates presented while ready=0 (or with clear=1) are
// silently discarded, so the master must check ready if it cares about loss.
interface param_pattern_history_table_if #(
  parameter int XLEN      = 32,
  parameter int HIST_BITS = 3,
  parameter int CTR_W     = 2,
  parameter int N_UPD     = 2
);
  logic                             clear;
  logic                             ready;
  logic                             rd_valid;
  logic [XLEN-1:0]                  rd_pc;
  logic [HIST_BITS-1:0]             rd_hist;
  logic                             pred_valid;
  logic                             pred_taken;
  logic [CTR_W-1:0]                 pred_ctr;
  logic [N_UPD-1:0]                 upd_valid;
  logic [N_UPD-1:0][XLEN-1:0]       upd_pc;
  logic [N_UPD-1:0][HIST_BITS-1:0]  upd_hist;
  logic [N_UPD-1:0]                 upd_taken;

  modport master (
    output clear, rd_valid, rd_pc, rd_hist, upd_valid, upd_pc, upd_hist, upd_taken,
    input  ready, pred_valid, pred_taken, pred_ctr
  );

  modport slave (
    input  clear, rd_valid, rd_pc, rd_hist, upd_valid, upd_pc, upd_hist, upd_taken,
    output ready, pred_valid, pred_taken, pred_ctr
  );
endinterface

// File: rtl/param_pattern_history_table_index_hash.sv
// Combinational table index from a PC and a history value.
//   pc_i   : full PC; only pc_i[2 +: PC_IDX_BITS] is used (upper bits alias)
//   hist_i : branch history
//   idx_o  : table index, concatenation or XOR hash depending on HASH_MODE
module param_pattern_history_table_index_hash
  import param_pattern_history_table_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_IDX_BITS = 8,
  parameter int HIST_BITS   = 3,
  parameter int HASH_MODE   = 0,
  parameter int IDX_W       = pht_idx_w(PC_IDX_BITS, HIST_BITS, HASH_MODE)
) (
  input  logic [XLEN-1:0]      pc_i,
  input  logic [HIST_BITS-1:0] hist_i,
  output logic [IDX_W-1:0]     idx_o
);

  assign idx_o = IDX_W'(pht_index(32'(pc_i[2 +: PC_IDX_BITS]), 32'(hist_i),
                                  HIST_BITS, HASH_MODE));

  // Instruction-alignment bits and PC bits above the index window are ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[XLEN-1:2+PC_IDX_BITS], pc_i[1:0]};

endmodule

// File: rtl/param_pattern_history_table.sv
// Two-level pattern history table of CTR_W-bit saturating counters.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave side of the table bundle (lookup, updates, clear, ready)
//   fsm_state_o  : current table state, for observation
// After reset or clear the table walks every entry writing the weakly-not-taken
// value, one entry per cycle, then raises ready. Lookups return a registered
// counter one cycle later; a same-cycle winning update to the looked-up entry
// is forwarded so the prediction shows the post-update value.
module param_pattern_history_table
  import param_pattern_history_table_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_IDX_BITS = 8,
  parameter int HIST_BITS   = 3,
  parameter int CTR_W       = 2,
  parameter int N_UPD       = 2,
  parameter int HASH_MODE   = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  param_pattern_history_table_if.slave         bus,
  output pht_fsm_e                             fsm_state_o
);

  localparam int               IDX_W    = pht_idx_w(PC_IDX_BITS, HIST_BITS, HASH_MODE);
  localparam int               DEPTH    = pht_depth(PC_IDX_BITS, HIST_BITS, HASH_MODE);
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  pht_fsm_e         state_q;
  logic [IDX_W-1:0] init_ptr_q;
  logic [CTR_W-1:0] mem_q [DEPTH];
  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [CTR_W-1:0] pred_ctr_q;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx [N_UPD];
  logic [CTR_W-1:0] upd_new [N_UPD];
  logic             upd_en;
  logic             byp_hit;
  logic [CTR_W-1:0] byp_val;
  logic [CTR_W-1:0] pred_ctr_d;

  param_pattern_history_table_index_hash #(
    .XLEN(XLEN), .PC_IDX_BITS(PC_IDX_BITS), .HIST_BITS(HIST_BITS),
    .HASH_MODE(HASH_MODE), .IDX_W(IDX_W)
  ) u_rd_hash (
    .pc_i(bus.rd_pc), .hist_i(bus.rd_hist), .idx_o(rd_idx)
  );

  for (genvar p = 0; p < N_UPD; p++) begin : g_upd
    param_pattern_history_table_index_hash #(
      .XLEN(XLEN), .PC_IDX_BITS(PC_IDX_BITS), .HIST_BITS(HIST_BITS),
      .HASH_MODE(HASH_MODE), .IDX_W(IDX_W)
    ) u_upd_hash (
      .pc_i(bus.upd_pc[p]), .hist_i(bus.upd_hist[p]), .idx_o(upd_idx[p])
    );
    assign upd_new[p] = CTR_W'(pht_sat_next(32'(mem_q[upd_idx[p]]), bus.upd_taken[p], CTR_W));
  end

  // Updates land only in READY, and a clear in the same cycle discards them.
  assign upd_en = (state_q == PHT_READY) && !bus.clear && !reset;

  // Forwarding: scanning ports upward leaves the highest-numbered valid port
  // hitting the read index, which is exactly the update that wins the entry.
  always_comb begin
    byp_hit = 1'b0;
    byp_val = '0;
    for (int p = 0; p < N_UPD; p++) begin
      if (upd_en && bus.upd_valid[p] && (upd_idx[p] == rd_idx)) begin
        byp_hit = 1'b1;
        byp_val = upd_new[p];
      end
    end
  end

  // Lookups during initialisation report a zero counter.
  always_comb begin
    pred_ctr_d = '0;
    if (state_q == PHT_READY) pred_ctr_d = byp_hit ? byp_val : mem_q[rd_idx];
  end

  // Table storage: no reset, so it can map onto a RAM. Later ports are
  // written last, which resolves same-entry collisions in favour of the
  // highest-numbered port.
  always_ff @(posedge clock) begin
    if (state_q == PHT_INIT) begin
      mem_q[init_ptr_q] <= INIT_VAL;
    end else if (upd_en) begin
      for (int p = 0; p < N_UPD; p++) begin
        if (bus.upd_valid[p]) mem_q[upd_idx[p]] <= upd_new[p];
      end
    end
  end

  // Initialisation FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= PHT_INIT;
      init_ptr_q <= '0;
    end else begin
      case (state_q)
        PHT_INIT: begin
          if (bus.clear) begin
            init_ptr_q <= '0;
          end else if (init_ptr_q == LAST_IDX) begin
            state_q    <= PHT_READY;
            init_ptr_q <= '0;
          end else begin
            init_ptr_q <= init_ptr_q + IDX_W'(1);
          end
        end
        PHT_READY: begin
          if (bus.clear) begin
            state_q    <= PHT_INIT;
            init_ptr_q <= '0;
          end
        end
        default: begin
          state_q    <= PHT_INIT;
          init_ptr_q <= '0;
        end
      endcase
    end
  end

  // Prediction registers hold their value while no lookup is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= '0;
    end else begin
      pred_valid_q <= bus.rd_valid;
      if (bus.rd_valid) begin
        pred_ctr_q   <= pred_ctr_d;
        pred_taken_q <= pred_ctr_d[CTR_W-1];
      end
    end
  end

  assign bus.ready      = (state_q == PHT_READY);
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_ctr   = pred_ctr_q;
  assign fsm_state_o    = state_q;

endmodule
